garbled_table_serializer: RTL and testbench

Downstream stage of the 4-hash AND garbler. Captures each completed gate result: output label Gc, three garbled-table rows toSend01/10/11, and the gate id. Forwards Gc to the wire-label store as a one-cycle pulse. Buffers the table rows plus gid in a small FIFO and streams them as fixed 10-word, 32-bit frames on a valid/ready/last stream toward the host DMA.

---
 rtl/gc_pkg.sv | 17 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/garbled_table_serializer.sv | 122 ++++++++++++
 tb/tb_garbled_table_serializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared widths, entry layout and FSM encoding for the garbled table serializer.
package gc_pkg;
   localparam int GID_W       = 64;
   localparam int LABEL_W     = 80;
   localparam int FRAME_WORDS = 10;
   localparam int PAD_W       = 16;
   localparam int ENTRY_W     = GID_W + 3*LABEL_W;

   typedef struct packed {
      logic [GID_W-1:0]   gid;
      logic [LABEL_W-1:0] t01;
      logic [LABEL_W-1:0] t10;
      logic [LABEL_W-1:0] t11;
   } entry_t;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;
endpackage

// File: rtl/sync_fifo.sv
// Plain synchronous FIFO; the caller must never push when full or pop when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]            count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (push) begin
         mem_d[wptr_q] = wdata;
         wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop) rptr_d = rptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
endmodule

// File: rtl/garbled_table_serializer.sv
// Captures garbler results, pulses Gc to the label store and streams gid + table
// rows as 10-word frames toward the host DMA.
module garbled_table_serializer
   import gc_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   input  logic [GID_W-1:0]       in_gid,
   input  logic [LABEL_W-1:0]     in_gc,
   input  logic [LABEL_W-1:0]     in_t01,
   input  logic [LABEL_W-1:0]     in_t10,
   input  logic [LABEL_W-1:0]     in_t11,
   output logic                   label_valid,
   output logic [LABEL_W-1:0]     label_gc,
   output logic [GID_W-1:0]       label_gid,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [DATA_W-1:0]      m_tdata,
   output logic                   m_tlast,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   overflow,
   input  logic                   overflow_clr
);
   localparam int         CNT_W  = $clog2(DEPTH) + 1;
   localparam logic [3:0] LAST_W = 4'(FRAME_WORDS - 1);

   logic               in_valid_q, in_valid_d;
   logic               label_valid_q, label_valid_d;
   logic [LABEL_W-1:0] label_gc_q, label_gc_d;
   logic [GID_W-1:0]   label_gid_q, label_gid_d;
   logic               overflow_q, overflow_d;
   state_e             state_q, state_d;
   logic [3:0]         wcnt_q, wcnt_d;

   logic               cap, push, pop, accept;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   entry_t             wentry, head;
   logic [FRAME_WORDS-1:0][DATA_W-1:0] frame_w;

   assign cap    = in_valid & ~in_valid_q;
   // Full check uses the registered count only: a same-cycle pop does not make room.
   assign push   = cap & ~fifo_full;
   assign accept = (state_q == SEND) & m_tready;
   assign pop    = accept & (wcnt_q == LAST_W);
   assign wentry = '{gid: in_gid, t01: in_t01, t10: in_t10, t11: in_t11};

   sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wdata   (wentry),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      in_valid_d    = in_valid;
      label_valid_d = cap;
      label_gc_d    = cap ? in_gc  : label_gc_q;
      label_gid_d   = cap ? in_gid : label_gid_q;
      overflow_d    = overflow_q;
      if (overflow_clr)     overflow_d = 1'b0;
      if (cap & fifo_full)  overflow_d = 1'b1;
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: if (!fifo_empty) begin
            state_d = SEND;
            wcnt_d  = '0;
         end
         SEND: if (accept) begin
            if (wcnt_q == LAST_W) begin
               wcnt_d = '0;
               // Stay in SEND if anything remains after the pop, incl. a same-cycle push.
               if (!((fifo_count > CNT_W'(1)) || push)) state_d = IDLE;
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         in_valid_q    <= 1'b0;
         label_valid_q <= 1'b0;
         label_gc_q    <= '0;
         label_gid_q   <= '0;
         overflow_q    <= 1'b0;
         state_q       <= IDLE;
         wcnt_q        <= '0;
      end else begin
         in_valid_q    <= in_valid_d;
         label_valid_q <= label_valid_d;
         label_gc_q    <= label_gc_d;
         label_gid_q   <= label_gid_d;
         overflow_q    <= overflow_d;
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
      end
   end

   // Frame word 0 sits in the top slice, so index from the top down.
   assign frame_w     = {head, {PAD_W{1'b0}}};
   assign m_tvalid    = (state_q == SEND);
   assign m_tlast     = m_tvalid & (wcnt_q == LAST_W);
   assign m_tdata     = m_tvalid ? frame_w[LAST_W - wcnt_q] : '0;
   assign label_valid = label_valid_q;
   assign label_gc    = label_gc_q;
   assign label_gid   = label_gid_q;
   assign fifo_level  = fifo_count;
   assign overflow    = overflow_q;
endmodule

// File: tb/tb_garbled_table_serializer.sv
// Scoreboard bench: expected labels and frame words are queued as gates are driven.
module tb_garbled_table_serializer;
   logic        clk, reset_n, in_valid, m_tready, overflow_clr;
   logic [63:0] in_gid;
   logic [79:0] in_gc, in_t01, in_t10, in_t11;
   logic        label_valid, m_tvalid, m_tlast, overflow;
   logic [79:0] label_gc;
   logic [63:0] label_gid;
   logic [31:0] m_tdata;
   logic [2:0]  fifo_level;

   garbled_table_serializer #(.DEPTH(4), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_gid(in_gid),
      .in_gc(in_gc), .in_t01(in_t01), .in_t10(in_t10), .in_t11(in_t11),
      .label_valid(label_valid), .label_gc(label_gc), .label_gid(label_gid),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] d; logic l; } wexp_t;
   typedef struct packed { logic [63:0] gid; logic [79:0] gc; } lexp_t;

   wexp_t       exp_q[$];
   lexp_t       lab_q[$];
   logic [31:0] obs_q[$];
   int          n_chk = 0, n_fail = 0, lab_cnt = 0, acc_cnt = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_frame(input logic [63:0] gid, input logic [79:0] t01, t10, t11);
      logic [319:0] f;
      wexp_t w;
      f = {gid, t01, t10, t11, 16'h0000};
      for (int i = 0; i < 10; i++) begin
         w.d = f[319-32*i -: 32];
         w.l = (i == 9);
         exp_q.push_back(w);
      end
   endtask

   task automatic set_gate(input logic [63:0] gid, input logic [79:0] gc, t01, t10, t11,
                           input bit acc);
      lexp_t le;
      in_gid = gid; in_gc = gc; in_t01 = t01; in_t10 = t10; in_t11 = t11;
      in_valid = 1'b1;
      le.gid = gid; le.gc = gc;
      lab_q.push_back(le);
      if (acc) expect_frame(gid, t01, t10, t11);
   endtask

   task automatic rnd_gate(input logic [63:0] gid, input bit acc);
      set_gate(gid, 80'({$urandom(), $urandom(), $urandom()}),
               80'({$urandom(), $urandom(), $urandom()}),
               80'({$urandom(), $urandom(), $urandom()}),
               80'({$urandom(), $urandom(), $urandom()}), acc);
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
      tick();
      chk(tag, 128'(exp_q.size()), 128'(0));
   endtask

   // Output monitor: labels, stream words and stall stability.
   initial begin
      lexp_t       le;
      wexp_t       we;
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_stall = 1'b0;
         end else begin
            if (label_valid) begin
               lab_cnt++;
               chk("lab_pending", 128'(lab_q.size() != 0), 128'(1));
               if (lab_q.size() != 0) begin
                  le = lab_q.pop_front();
                  chk("lab_gid", 128'(label_gid), 128'(le.gid));
                  chk("lab_gc", 128'(label_gc), 128'(le.gc));
               end
            end
            if (prev_stall) begin
               chk("stall_vld", 128'(m_tvalid), 128'(1));
               chk("stall_data", 128'(m_tdata), 128'(prev_data));
               chk("stall_last", 128'(m_tlast), 128'(prev_last));
            end
            if (m_tvalid && m_tready) begin
               acc_cnt++;
               obs_q.push_back(m_tdata);
               chk("word_pending", 128'(exp_q.size() != 0), 128'(1));
               if (exp_q.size() != 0) begin
                  we = exp_q.pop_front();
                  chk("word_data", 128'(m_tdata), 128'(we.d));
                  chk("word_last", 128'(m_tlast), 128'(we.l));
               end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lb, base, vcnt;
      reset_n = 1'b0; in_valid = 1'b0; m_tready = 1'b0; overflow_clr = 1'b0;
      in_gid = '0; in_gc = '0; in_t01 = '0; in_t10 = '0; in_t11 = '0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_label_valid", 128'(label_valid), 128'(0));
      chk("rst_label_gc", 128'(label_gc), 128'(0));
      chk("rst_label_gid", 128'(label_gid), 128'(0));
      chk("rst_tvalid", 128'(m_tvalid), 128'(0));
      chk("rst_tdata", 128'(m_tdata), 128'(0));
      chk("rst_tlast", 128'(m_tlast), 128'(0));
      chk("rst_level", 128'(fifo_level), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
      tick();
      reset_n = 1'b1;
      tick();

      // single gate, latency and word layout
      m_tready = 1'b1;
      obs_q.delete();
      lb = lab_cnt;
      set_gate(64'h0000_0001_0000_0002, {5{16'hAAAA}}, {5{16'h1111}}, {5{16'h2222}},
               {5{16'h3333}}, 1'b1);
      tick();
      @(negedge clk);
      chk("t1_label_n1", 128'(label_valid), 128'(1));
      chk("t1_tvalid_n1", 128'(m_tvalid), 128'(0));
      tick();
      @(negedge clk);
      chk("t1_tvalid_n2", 128'(m_tvalid), 128'(1));
      repeat (3) tick();
      in_valid = 1'b0;
      drain("t1_drain");
      chk("t1_labels", 128'(lab_cnt - lb), 128'(1));
      chk("t1_words", 128'(obs_q.size()), 128'(10));
      chk("t1_w0", 128'(obs_q[0]), 128'(32'h0000_0001));
      chk("t1_w1", 128'(obs_q[1]), 128'(32'h0000_0002));
      chk("t1_w2", 128'(obs_q[2]), 128'(32'h1111_1111));
      chk("t1_w9", 128'(obs_q[9]), 128'(32'h3333_0000));

      // backpressure 1,0,0,1,...
      m_tready = 1'b0;
      rnd_gate(64'h20, 1'b1);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         m_tready = (i % 4 == 0) || (i % 4 == 3);
         tick();
      end
      m_tready = 1'b1;
      drain("t2_drain");

      // overflow with 5 gates into a 4-deep FIFO
      m_tready = 1'b0;
      lb = lab_cnt;
      for (int g = 1; g <= 5; g++) rnd_gate(64'(g), g <= 4);
      @(negedge clk);
      chk("t3_level", 128'(fifo_level), 128'(4));
      chk("t3_overflow", 128'(overflow), 128'(1));
      chk("t3_labels", 128'(lab_cnt - lb), 128'(5));
      tick();
      m_tready = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (m_tvalid) vcnt++;
      end
      chk("t3_b2b_words", 128'(vcnt), 128'(40));
      drain("t3_drain");
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      @(negedge clk);
      chk("t3_ovf_clr", 128'(overflow), 128'(0));

      // capture while full, in the same cycle w9 is accepted
      tick();
      m_tready = 1'b0;
      for (int g = 11; g <= 14; g++) rnd_gate(64'(g), 1'b1);
      @(negedge clk);
      chk("t4_level_full", 128'(fifo_level), 128'(4));
      tick();
      m_tready = 1'b1;
      repeat (9) tick();
      rnd_gate(64'd15, 1'b0);
      @(negedge clk);
      chk("t4_overflow", 128'(overflow), 128'(1));
      chk("t4_level", 128'(fifo_level), 128'(3));
      drain("t4_drain");

      // reset after w4 of a frame
      base = acc_cnt;
      rnd_gate(64'h30, 1'b1);
      for (int i = 0; i < 100; i++) begin
         if (acc_cnt == base + 5) break;
         tick();
      end
      chk("t5_w4_reached", 128'(acc_cnt - base), 128'(5));
      reset_n  = 1'b0;
      m_tready = 1'b0;
      tick();
      @(negedge clk);
      chk("t5_tvalid", 128'(m_tvalid), 128'(0));
      chk("t5_tlast", 128'(m_tlast), 128'(0));
      chk("t5_level", 128'(fifo_level), 128'(0));
      chk("t5_overflow", 128'(overflow), 128'(0));
      exp_q.delete();
      tick();
      reset_n  = 1'b1;
      m_tready = 1'b1;
      rnd_gate(64'h31, 1'b1);
      drain("t5_drain");

      // in_valid already high when reset releases
      reset_n = 1'b0;
      lb = lab_cnt;
      set_gate(64'h40, 80'h5, 80'h6, 80'h7, 80'h8, 1'b1);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (5) tick();
      in_valid = 1'b0;
      drain("t6_drain");
      chk("t6_labels", 128'(lab_cnt - lb), 128'(1));
      chk("end_lab_q", 128'(lab_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
